// File: rtl/seq_multiplier_core.sv
// Sequential add-shift multiplier: WIDTH x WIDTH -> 2*WIDTH product held in {A,B},
// with X as sign extension (signed mode) or carry (unsigned mode).
module seq_multiplier_core #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               ClearA_LoadB,
    input  logic               Start,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Din,
    output logic [WIDTH-1:0]   A_out,
    output logic [WIDTH-1:0]   B_out,
    output logic               X_out,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             x_r;
    logic             mode_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] count_r;

    logic [WIDTH:0]   sum_s;
    logic             sub_s;
    logic             fill_s;

    // Extend an operand to WIDTH+1 bits: sign-extend when sgn is set, zero-extend otherwise.
    function automatic logic [WIDTH:0] ext_op(input logic [WIDTH-1:0] v, input logic sgn);
        return {sgn & v[WIDTH-1], v};
    endfunction

    // Partial-product adder; the MSB of a signed multiplier carries negative weight.
    always_comb begin
        sub_s  = 1'b0;
        sum_s  = {(WIDTH+1){1'b0}};
        fill_s = 1'b0;
        sub_s  = mode_r & (count_r == LAST_CNT);
        if (sub_s) begin
            sum_s = ext_op(a_r, mode_r) - ext_op(s_r, mode_r);
        end else begin
            sum_s = ext_op(a_r, mode_r) + ext_op(s_r, mode_r);
        end
        if (mode_r) begin
            fill_s = x_r;
        end else begin
            fill_s = 1'b0;
        end
    end

    // Control FSM and datapath registers; status flags are registered with the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            x_r     <= 1'b0;
            mode_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Load takes precedence; a held Start is acted on once the load is released.
                    if (ClearA_LoadB) begin
                        a_r <= {WIDTH{1'b0}};
                        x_r <= 1'b0;
                        b_r <= Din;
                    end else if (Start) begin
                        state_r <= ST_CLR;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    a_r     <= {WIDTH{1'b0}};
                    x_r     <= 1'b0;
                    s_r     <= Din;
                    mode_r  <= Signed_Mode;
                    count_r <= {CNT_W{1'b0}};
                    state_r <= ST_ADD;
                end
                ST_ADD: begin
                    if (b_r[0]) begin
                        {x_r, a_r} <= sum_s;
                    end else begin
                        a_r <= a_r;
                        x_r <= x_r;
                    end
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {x_r, a_r, b_r} <= {fill_s, x_r, a_r, b_r[WIDTH-1:1]};
                    count_r         <= count_r + CNT_W'(1);
                    if (count_r == LAST_CNT) begin
                        state_r <= ST_HOLD;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_ADD;
                    end
                end
                ST_HOLD: begin
                    // Leaving HOLD needs Start low, so a held Start never retriggers.
                    if (ClearA_LoadB) begin
                        a_r <= {WIDTH{1'b0}};
                        x_r <= 1'b0;
                        b_r <= Din;
                    end else if (!Start) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign A_out   = a_r;
    assign B_out   = b_r;
    assign X_out   = x_r;
    assign Product = {a_r, b_r};
    assign Busy    = busy_r;
    assign Done    = done_r;

endmodule

// File: tb/tb_seq_multiplier_core.sv
// Self-checking bench for seq_multiplier_core: directed cases plus randomized
// operands compared against an arithmetic reference product.
module tb_seq_multiplier_core;

    localparam int W = 8;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           ClearA_LoadB;
    logic           Start;
    logic           Signed_Mode;
    logic [W-1:0]   Din;
    logic [W-1:0]   A_out;
    logic [W-1:0]   B_out;
    logic           X_out;
    logic [2*W-1:0] Product;
    logic           Busy;
    logic           Done;

    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   model_b;

    seq_multiplier_core #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ClearA_LoadB (ClearA_LoadB),
        .Start        (Start),
        .Signed_Mode  (Signed_Mode),
        .Din          (Din),
        .A_out        (A_out),
        .B_out        (B_out),
        .X_out        (X_out),
        .Product      (Product),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] b, input logic [W-1:0] s,
                                               input logic sgn);
        longint p;
        if (sgn) p = longint'($signed(b)) * longint'($signed(s));
        else     p = longint'(b) * longint'(s);
        return p[2*W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_b(input logic [W-1:0] v);
        ClearA_LoadB = 1'b1;
        Din          = v;
        tick();
        ClearA_LoadB = 1'b0;
        model_b      = v;
        chk("load_b", B_out, v);
        chk("load_a", A_out, 0);
    endtask

    // One multiply of model_b by s; optional load pulse while busy, extra Start-held
    // cycles in HOLD, and a load inside HOLD before release.
    task automatic multiply(input logic [W-1:0] s, input logic sgn, input bit disturb,
                            input int hold_cycles, input bit hold_load);
        logic [2*W-1:0] exp;
        int             lat;
        int             stuck;
        exp         = ref_mul(model_b, s, sgn);
        Start       = 1'b1;
        Din         = s;
        Signed_Mode = sgn;
        tick();
        chk("busy_after_start", Busy, 1);
        tick();
        lat         = 1;
        Din         = W'($urandom);
        Signed_Mode = ~sgn;
        if (disturb) begin
            ClearA_LoadB = 1'b1;
            tick();
            ClearA_LoadB = 1'b0;
            lat++;
        end
        while (!Done && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", lat, 17);
        chk("product", Product, exp);
        chk("x_out", X_out, sgn ? exp[2*W-1] : 1'b0);
        chk("busy_in_hold", Busy, 0);
        model_b = exp[W-1:0];
        if (hold_cycles > 0) begin
            stuck = 0;
            repeat (hold_cycles) begin
                tick();
                if (Done !== 1'b1 || Busy !== 1'b0 || Product !== exp) stuck++;
            end
            chk("hold_stable", stuck, 0);
        end
        if (hold_load) begin
            ClearA_LoadB = 1'b1;
            Din          = 8'h3C;
            tick();
            ClearA_LoadB = 1'b0;
            chk("hold_load_done", Done, 1);
            chk("hold_load_b", B_out, 8'h3C);
            chk("hold_load_a", A_out, 0);
            exp     = {8'h00, 8'h3C};
            model_b = 8'h3C;
        end
        Start = 1'b0;
        tick();
        chk("idle_done", Done, 0);
        chk("idle_busy", Busy, 0);
        chk("idle_product", Product, exp);
    endtask

    initial begin
        Reset        = 1'b1;
        ClearA_LoadB = 1'b0;
        Start        = 1'b0;
        Signed_Mode  = 1'b0;
        Din          = 8'h00;
        model_b      = 8'h00;
        tick();
        tick();
        chk("reset_product", Product, 0);
        chk("reset_x", X_out, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        Reset = 1'b0;
        tick();

        // Directed arithmetic cases
        load_b(8'hFF);
        multiply(8'hFF, 1'b0, 1'b0, 0, 1'b0);
        chk("t1_unsigned_ff", Product, 16'hFE01);
        load_b(8'hFF);
        multiply(8'hFF, 1'b1, 1'b0, 0, 1'b0);
        chk("t2_signed_m1", Product, 16'h0001);
        load_b(8'h80);
        multiply(8'h80, 1'b1, 1'b0, 0, 1'b0);
        chk("t2_signed_80", Product, 16'h4000);
        load_b(8'hFD);
        multiply(8'h07, 1'b1, 1'b0, 0, 1'b0);
        chk("t3_signed_neg", Product, 16'hFFEB);
        chk("t3_x", X_out, 1);
        load_b(8'h03);
        multiply(8'h02, 1'b0, 1'b0, 0, 1'b0);
        chk("t4_first", Product, 16'h0006);
        multiply(8'h02, 1'b0, 1'b0, 0, 1'b0);
        chk("t4_chain", Product, 16'h000C);

        // Reset during the fifth SHIFT cycle
        load_b(8'h5A);
        Start       = 1'b1;
        Din         = 8'h33;
        Signed_Mode = 1'b0;
        tick();
        repeat (10) tick();
        chk("t5_busy_before_reset", Busy, 1);
        Reset = 1'b1;
        Start = 1'b0;
        tick();
        Reset = 1'b0;
        chk("t5_product", Product, 0);
        chk("t5_busy", Busy, 0);
        chk("t5_done", Done, 0);
        chk("t5_x", X_out, 0);
        model_b = 8'h00;

        // Load pulse while busy must be ignored
        load_b(8'h0B);
        multiply(8'h0D, 1'b0, 1'b1, 0, 1'b0);
        chk("t5_ignore_load", Product, 16'h008F);

        // Load and Start together in IDLE: load first, multiply next cycle
        ClearA_LoadB = 1'b1;
        Start        = 1'b1;
        Din          = 8'h11;
        tick();
        ClearA_LoadB = 1'b0;
        chk("load_wins_busy", Busy, 0);
        chk("load_wins_b", B_out, 8'h11);
        model_b = 8'h11;
        multiply(8'h05, 1'b0, 1'b0, 0, 1'b0);
        chk("load_then_start", Product, 16'h0055);

        // Start held ~40 cycles: single multiply, then a load inside HOLD
        load_b(8'hC3);
        multiply(W'($urandom), 1'b1, 1'b0, 22, 1'b0);
        load_b(8'h27);
        multiply(W'($urandom), 1'b0, 1'b0, 5, 1'b1);

        // Randomized operands, mode and chaining
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) load_b(W'($urandom));
            multiply(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
